// File: rtl/dispatcher_pkg.sv
// Shared definitions for the thread dispatcher.
// Holds the lane count, the cta_size / unrolling_factor decodes, the bit
// ranges of the register classes in the input register bitmap, the scan
// FSM state type and the write-back register decode.
package dispatcher_pkg;

    localparam int LANES       = 4;
    localparam int TID_W       = 10;
    localparam int PTR_W       = 11;
    localparam int MAX_THREADS = 1024;
    localparam int BITMAP_W    = 66;

    // Register classes inside input_register_bitmap
    localparam int GPR_LO   = 0;
    localparam int GPR_HI   = 31;
    localparam int CONST_LO = 32;
    localparam int CONST_HI = 63;
    localparam int PRED_LO  = 64;
    localparam int PRED_HI  = 65;

    // Tracked registers: 32 GPRs followed by 2 predicates
    localparam int NUM_GPR     = 32;
    localparam int NUM_PRED    = 2;
    localparam int NUM_TRACKED = NUM_GPR + NUM_PRED;

    // cta_size encodings
    localparam logic [1:0] CTA_256 = 2'd0;
    localparam logic [1:0] CTA_512 = 2'd1;

    // unrolling_factor encodings
    localparam logic [1:0] UF_1 = 2'd0;
    localparam logic [1:0] UF_2 = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of threads in the CTA; both upper codes mean 1024.
    function automatic logic [PTR_W-1:0] cta_threads(input logic [1:0] size);
        case (size)
            CTA_256: cta_threads = 11'd256;
            CTA_512: cta_threads = 11'd512;
            default: cta_threads = 11'd1024;
        endcase
    endfunction

    // Number of lanes used; both upper codes mean all four lanes.
    function automatic logic [2:0] lane_count(input logic [1:0] uf);
        case (uf)
            UF_1:    lane_count = 3'd1;
            UF_2:    lane_count = 3'd2;
            default: lane_count = 3'd4;
        endcase
    endfunction

    // One-hot of the tracked register addressed by a write-back.
    // GPRs 0-31 map to bits 0-31, predicates 64/65 to bits 32/33,
    // anything else (constants, unused indices) tracks nothing.
    function automatic logic [NUM_TRACKED-1:0] tracked_onehot(input logic [6:0] idx);
        tracked_onehot = '0;
        if (idx < 7'd32)
            tracked_onehot[idx[4:0]] = 1'b1;
        else if (idx == 7'd64)
            tracked_onehot[NUM_GPR] = 1'b1;
        else if (idx == 7'd65)
            tracked_onehot[NUM_GPR + 1] = 1'b1;
    endfunction

endpackage

// File: rtl/dispatcher_if.sv
// Dispatch-side bus between the dispatcher and the lane consumers.
//   dispatch_fifo_pop     per-lane pop request from the consumers
//   dispatch_tid_0..3     head TID of each lane FIFO
//   dispatch_valid_0..3   lane FIFO non-empty
//   dispatch_fifo_empty   all lane FIFOs empty
// master: the dispatcher; slave: the lane consumers.
interface dispatcher_if;
    import dispatcher_pkg::*;

    logic [LANES-1:0] dispatch_fifo_pop;
    logic [TID_W-1:0] dispatch_tid_0;
    logic [TID_W-1:0] dispatch_tid_1;
    logic [TID_W-1:0] dispatch_tid_2;
    logic [TID_W-1:0] dispatch_tid_3;
    logic             dispatch_valid_0;
    logic             dispatch_valid_1;
    logic             dispatch_valid_2;
    logic             dispatch_valid_3;
    logic             dispatch_fifo_empty;

    modport master (
        input  dispatch_fifo_pop,
        output dispatch_tid_0, dispatch_tid_1, dispatch_tid_2, dispatch_tid_3,
        output dispatch_valid_0, dispatch_valid_1, dispatch_valid_2, dispatch_valid_3,
        output dispatch_fifo_empty
    );

    modport slave (
        output dispatch_fifo_pop,
        input  dispatch_tid_0, dispatch_tid_1, dispatch_tid_2, dispatch_tid_3,
        input  dispatch_valid_0, dispatch_valid_1, dispatch_valid_2, dispatch_valid_3,
        input  dispatch_fifo_empty
    );

endinterface

// File: rtl/dispatch_lane_fifo.sv
// Per-lane dispatch FIFO holding thread IDs.
//   clk, rst     clock, asynchronous active-high reset
//   push, data   write request and TID (ignored when full)
//   pop          read request (ignored when empty)
//   head         oldest entry, combinational from FIFO state
//   empty, full  occupancy flags
module dispatch_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= data;
    end

endmodule

// File: rtl/dispatcher.sv
// CTA thread dispatcher with register scoreboard.
// After fetch_done it scans the CTA in windows of 1/2/4 TIDs, pushes active,
// unblocked threads into per-lane FIFOs in order, then drains and signals done.
//   clk, rst                 clock, asynchronous active-high reset
//   unrolling_factor         lanes used (1/2/4)
//   input_register_bitmap    registers read by the kernel
//   active_mask              per-TID active bit
//   cta_size                 thread count (256/512/1024)
//   fetch_done               start pulse, honoured only when idle
//   wb_valid, wb_tid_bitmap, ld_dest_reg   scoreboard set/clear updates
//   dsp                      dispatch bus (pops in, lane heads/valids out)
//   dispatcher_busy          scan or drain in progress
//   dispatcher_done          CTA fully scanned and drained
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              unrolling_factor,
    input  logic [BITMAP_W-1:0]     input_register_bitmap,
    input  logic [MAX_THREADS-1:0]  active_mask,
    input  logic [1:0]              cta_size,
    input  logic                    fetch_done,
    input  logic                    wb_valid,
    input  logic [MAX_THREADS-1:0]  wb_tid_bitmap,
    input  logic [7:0]              ld_dest_reg,
    dispatcher_if.master            dsp,
    output logic                    dispatcher_busy,
    output logic                    dispatcher_done
);

    state_t                  state;
    state_t                  next_state;
    logic [PTR_W-1:0]        ptr;
    logic [1:0]              uf_q;
    logic [1:0]              cta_q;
    logic [BITMAP_W-1:0]     bitmap_q;
    logic [MAX_THREADS-1:0]  mask_q;
    logic [MAX_THREADS-1:0]  pending [NUM_TRACKED];

    logic [NUM_TRACKED-1:0]  sel;
    logic                    unused_const_bits;
    logic [2:0]              lanes_q;
    logic [PTR_W-1:0]        ptr_next;
    logic [TID_W-1:0]        win_tid [NUM_LANES];
    logic [NUM_LANES-1:0]    blocked;
    logic [NUM_LANES-1:0]    need_push;
    logic                    window_ok;
    logic                    advance;
    logic [NUM_LANES-1:0]    push;
    logic [TID_W-1:0]        head [NUM_LANES];
    logic [NUM_LANES-1:0]    empty;
    logic [NUM_LANES-1:0]    full;
    logic                    all_empty;
    logic [NUM_TRACKED-1:0]  wb_onehot;

    // Constants are latched with the bitmap but never tracked or blocking.
    assign sel               = {bitmap_q[PRED_HI:PRED_LO], bitmap_q[GPR_HI:GPR_LO]};
    assign unused_const_bits = ^bitmap_q[CONST_HI:CONST_LO];
    assign lanes_q           = lane_count(uf_q);
    assign ptr_next          = ptr + PTR_W'(lanes_q);
    assign all_empty         = &empty;
    assign advance           = (state == SCAN) && window_ok;
    assign push              = advance ? need_push : '0;
    assign wb_onehot         = tracked_onehot(ld_dest_reg[6:0]);

    // Window evaluation: TID ptr+i targets lane i. The whole window moves as
    // one unit so that dispatch order stays strictly increasing by TID.
    always_comb begin
        window_ok = 1'b1;
        blocked   = '0;
        need_push = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            win_tid[i] = ptr[TID_W-1:0] + TID_W'(i);
            for (int r = 0; r < NUM_TRACKED; r++)
                blocked[i] = blocked[i] | (sel[r] & pending[r][win_tid[i]]);
            need_push[i] = (i < int'(lanes_q)) && mask_q[win_tid[i]];
            if (need_push[i] && (blocked[i] || full[i]))
                window_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Thread counts are multiples of four, so the pointer lands exactly on
    // the CTA size when the last window advances.
    always_comb begin
        next_state      = state;
        dispatcher_busy = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_done)
                    next_state = SCAN;
            end
            SCAN: begin
                dispatcher_busy = 1'b1;
                if (advance && (ptr_next >= cta_threads(cta_q)))
                    next_state = DRAIN;
            end
            DRAIN: begin
                dispatcher_busy = 1'b1;
                if (all_empty)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Configuration latch, scan pointer and done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr             <= '0;
            uf_q            <= '0;
            cta_q           <= '0;
            bitmap_q        <= '0;
            mask_q          <= '0;
            dispatcher_done <= 1'b0;
        end else begin
            if (state == IDLE && fetch_done) begin
                ptr             <= '0;
                uf_q            <= unrolling_factor;
                cta_q           <= cta_size;
                bitmap_q        <= input_register_bitmap;
                mask_q          <= active_mask;
                dispatcher_done <= 1'b0;
            end else if (advance) begin
                ptr <= ptr_next;
            end
            if (state == DRAIN && all_empty)
                dispatcher_done <= 1'b1;
        end
    end

    // Scoreboard: one pending bit per tracked register per TID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_TRACKED; r++)
                pending[r] <= '0;
        end else if (wb_valid) begin
            for (int r = 0; r < NUM_TRACKED; r++) begin
                if (wb_onehot[r]) begin
                    if (ld_dest_reg[7])
                        pending[r] <= pending[r] | wb_tid_bitmap;
                    else
                        pending[r] <= pending[r] & ~wb_tid_bitmap;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dispatch_lane_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (TID_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .data  (win_tid[g]),
            .pop   (dsp.dispatch_fifo_pop[g]),
            .head  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    assign dsp.dispatch_tid_0      = head[0];
    assign dsp.dispatch_tid_1      = head[1];
    assign dsp.dispatch_tid_2      = head[2];
    assign dsp.dispatch_tid_3      = head[3];
    assign dsp.dispatch_valid_0    = !empty[0];
    assign dsp.dispatch_valid_1    = !empty[1];
    assign dsp.dispatch_valid_2    = !empty[2];
    assign dsp.dispatch_valid_3    = !empty[3];
    assign dsp.dispatch_fifo_empty = all_empty;

endmodule

// File: tb/tb_dispatcher.sv
// Directed self-checking bench for the dispatcher: a consumer model pops
// every lane, records which TIDs arrive on which lane, and the expected
// totals/lanes are hand-derived per scenario.
module tb_dispatcher;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    unrolling_factor;
    logic [65:0]   input_register_bitmap;
    logic [1023:0] active_mask;
    logic [1:0]    cta_size;
    logic          fetch_done;
    logic          wb_valid;
    logic [1023:0] wb_tid_bitmap;
    logic [7:0]    ld_dest_reg;
    logic          dispatcher_busy;
    logic          dispatcher_done;

    dispatcher_if dif ();

    dispatcher #(.FIFO_DEPTH(4), .NUM_LANES(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .unrolling_factor      (unrolling_factor),
        .input_register_bitmap (input_register_bitmap),
        .active_mask           (active_mask),
        .cta_size              (cta_size),
        .fetch_done            (fetch_done),
        .wb_valid              (wb_valid),
        .wb_tid_bitmap         (wb_tid_bitmap),
        .ld_dest_reg           (ld_dest_reg),
        .dsp                   (dif),
        .dispatcher_busy       (dispatcher_busy),
        .dispatcher_done       (dispatcher_done)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       seen [1024];
    int       lane_of [1024];
    int       total;
    int       lane_err;
    logic [3:0] lanes_hit;
    bit       pop_enable;
    int       cur_lanes;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_record();
        for (int t = 0; t < 1024; t++) begin
            seen[t]    = 0;
            lane_of[t] = -1;
        end
        total     = 0;
        lane_err  = 0;
        lanes_hit = '0;
    endtask

    // One clock: sample lane heads on the falling edge, consume them and
    // request the matching pops for the next rising edge.
    task automatic cycle();
        logic [9:0] tids [4];
        logic [3:0] vals;
        logic [3:0] pops;
        @(negedge clk);
        tids[0] = dif.dispatch_tid_0;
        tids[1] = dif.dispatch_tid_1;
        tids[2] = dif.dispatch_tid_2;
        tids[3] = dif.dispatch_tid_3;
        vals = {dif.dispatch_valid_3, dif.dispatch_valid_2, dif.dispatch_valid_1, dif.dispatch_valid_0};
        pops = '0;
        for (int i = 0; i < 4; i++) begin
            if (pop_enable && vals[i]) begin
                seen[tids[i]]++;
                lane_of[tids[i]] = i;
                total++;
                lanes_hit[i] = 1'b1;
                if (int'(tids[i]) % cur_lanes != i)
                    lane_err++;
                pops[i] = 1'b1;
            end
        end
        dif.dispatch_fifo_pop = pops;
    endtask

    task automatic apply_stimulus(input logic [1:0] uf, input logic [65:0] bitmap,
                                  input logic [1023:0] mask, input logic [1:0] size);
        cur_lanes = (uf == 2'd0) ? 1 : (uf == 2'd1) ? 2 : 4;
        clear_record();
        cycle();
        unrolling_factor      = uf;
        input_register_bitmap = bitmap;
        active_mask           = mask;
        cta_size              = size;
        fetch_done            = 1'b1;
        cycle();
        fetch_done            = 1'b0;
    endtask

    task automatic apply_writeback(input logic [7:0] dest, input logic [1023:0] tids);
        cycle();
        wb_valid      = 1'b1;
        ld_dest_reg   = dest;
        wb_tid_bitmap = tids;
        cycle();
        wb_valid      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!dispatcher_done && n < 3000) begin
            cycle();
            n++;
        end
        check_output({tag, "_done"}, 32'(dispatcher_done), 32'd1);
    endtask

    function automatic int count_dups();
        int d = 0;
        for (int t = 0; t < 1024; t++)
            if (seen[t] > 1) d++;
        return d;
    endfunction

    initial begin
        rst                   = 1'b1;
        unrolling_factor      = '0;
        input_register_bitmap = '0;
        active_mask           = '0;
        cta_size              = '0;
        fetch_done            = 1'b0;
        wb_valid              = 1'b0;
        wb_tid_bitmap         = '0;
        ld_dest_reg           = '0;
        dif.dispatch_fifo_pop = '0;
        pop_enable            = 1'b1;
        cur_lanes             = 4;
        clear_record();

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_busy",  32'(dispatcher_busy), 32'd0);
        check_output("rst_done",  32'(dispatcher_done), 32'd0);
        check_output("rst_empty", 32'(dif.dispatch_fifo_empty), 32'd1);
        check_output("rst_valid0", 32'(dif.dispatch_valid_0), 32'd0);
        rst = 1'b0;

        // Four active threads, 4-way: one per lane
        apply_stimulus(2'd2, 66'h1, 1024'hF, 2'd0);
        check_output("basic_busy", 32'(dispatcher_busy), 32'd1);
        wait_done("basic");
        check_output("basic_total", 32'(total), 32'd4);
        for (int t = 0; t < 4; t++)
            check_output($sformatf("basic_lane_tid%0d", t), 32'(lane_of[t]), 32'(t));
        check_output("basic_busy_end", 32'(dispatcher_busy), 32'd0);
        check_output("basic_empty_end", 32'(dif.dispatch_fifo_empty), 32'd1);

        // Sixteen threads with 1-, 2- and 4-way unrolling
        for (int u = 0; u < 3; u++) begin
            apply_stimulus(2'(u), 66'h1, 1024'hFFFF, 2'd0);
            wait_done($sformatf("unroll%0d", u));
            check_output($sformatf("unroll%0d_total", u), 32'(total), 32'd16);
            check_output($sformatf("unroll%0d_dups", u), 32'(count_dups()), 32'd0);
            check_output($sformatf("unroll%0d_laneerr", u), 32'(lane_err), 32'd0);
            check_output($sformatf("unroll%0d_lanes", u), 32'(lanes_hit),
                         (u == 0) ? 32'h1 : (u == 1) ? 32'h3 : 32'hF);
        end

        // GPR0 pending for TIDs 0-3 blocks the in-order scan until cleared
        apply_writeback(8'h80, 1024'hF);
        apply_stimulus(2'd2, 66'h7, 1024'hFF, 2'd0);
        repeat (20) cycle();
        check_output("sb_blocked_total", 32'(total), 32'd0);
        check_output("sb_blocked_busy", 32'(dispatcher_busy), 32'd1);
        apply_writeback(8'h00, 1024'hF);
        wait_done("sb");
        check_output("sb_total", 32'(total), 32'd8);
        check_output("sb_dups", 32'(count_dups()), 32'd0);

        // Constant registers never block
        apply_writeback(8'h80, 1024'hF);
        apply_stimulus(2'd2, 66'hF << 32, 1024'hF, 2'd0);
        wait_done("const");
        check_output("const_total", 32'(total), 32'd4);
        apply_writeback(8'h00, 1024'hF);

        // Predicate 64 pending on TID 0 blocks until cleared
        apply_writeback(8'hC0, 1024'h1);
        apply_stimulus(2'd2, 66'h1 << 64, 1024'h1, 2'd0);
        repeat (20) cycle();
        check_output("pred_blocked_total", 32'(total), 32'd0);
        apply_writeback(8'h40, 1024'h1);
        wait_done("pred");
        check_output("pred_total", 32'(total), 32'd1);

        // CTA size boundary: TIDs 511, 512, 1023 active
        apply_stimulus(2'd2, 66'h0, (1024'h1 << 511) | (1024'h1 << 512) | (1024'h1 << 1023), 2'd1);
        wait_done("cta512");
        check_output("cta512_total", 32'(total), 32'd1);
        check_output("cta512_tid511", 32'(seen[511]), 32'd1);
        apply_stimulus(2'd3, 66'h0, (1024'h1 << 511) | (1024'h1 << 512) | (1024'h1 << 1023), 2'd2);
        wait_done("cta1024");
        check_output("cta1024_total", 32'(total), 32'd3);
        check_output("cta1024_lane1023", 32'(lane_of[1023]), 32'd3);

        // Backpressure: no pops, lane 0 fills, scan stalls, then resumes
        pop_enable = 1'b0;
        apply_stimulus(2'd0, 66'h1, 1024'hFFFF, 2'd0);
        repeat (30) cycle();
        check_output("bp_busy", 32'(dispatcher_busy), 32'd1);
        check_output("bp_valid0", 32'(dif.dispatch_valid_0), 32'd1);
        check_output("bp_valid1", 32'(dif.dispatch_valid_1), 32'd0);
        check_output("bp_head0", 32'(dif.dispatch_tid_0), 32'd0);
        // A start pulse while busy must be ignored
        unrolling_factor = 2'd2;
        active_mask      = '1;
        fetch_done       = 1'b1;
        cycle();
        fetch_done       = 1'b0;
        pop_enable       = 1'b1;
        wait_done("bp");
        check_output("bp_total", 32'(total), 32'd16);
        check_output("bp_dups", 32'(count_dups()), 32'd0);
        check_output("bp_laneerr", 32'(lane_err), 32'd0);
        check_output("bp_tid15", 32'(seen[15]), 32'd1);

        // Reset mid-CTA aborts it
        pop_enable = 1'b0;
        apply_stimulus(2'd2, 66'h1, 1024'hFFFF, 2'd0);
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        check_output("abort_busy", 32'(dispatcher_busy), 32'd0);
        check_output("abort_empty", 32'(dif.dispatch_fifo_empty), 32'd1);
        check_output("abort_valid0", 32'(dif.dispatch_valid_0), 32'd0);
        repeat (2) cycle();
        rst = 1'b0;
        pop_enable = 1'b1;
        apply_stimulus(2'd2, 66'h1, 1024'h20, 2'd0);
        wait_done("after_abort");
        check_output("after_abort_total", 32'(total), 32'd1);
        check_output("after_abort_lane", 32'(lane_of[5]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning: entries per lane dispatch FIFO (power of 2).
REQ-002 Parameter NUM_LANES, default 4, meaning: number of dispatch lanes (fixed at 4).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 unrolling_factor  in  2  lanes used: 0=1 (lane 0), 1=2 (lanes 0-1), 2/3=4 (lanes 0-3).
REQ-007 input_register_bitmap  in  66  registers read by kernel: [31:0] GPR, [63:32] constants, [65:64] predicates.
REQ-008 active_mask  in  1024  per-TID active bit.
REQ-009 cta_size  in  2  thread count: 0=256, 1=512, 2/3=1024.
REQ-010 fetch_done  in  1  single-cycle start pulse.
REQ-011 wb_valid  in  1  scoreboard update strobe.
REQ-012 wb_tid_bitmap  in  1024  TIDs affected by the update.
REQ-013 ld_dest_reg  in  8  [7]=1 set pending / 0 clear pending; [6:0] register index 0-31 GPR, 64-65 predicate (others ignored).
REQ-014 dispatch_fifo_pop  in  4  per-lane pop.
REQ-015 dispatch_tid_0..3  out  10 each  head TID of lane FIFO.
REQ-016 dispatch_valid_0..3  out  1 each  lane FIFO non-empty.
REQ-017 dispatch_fifo_empty  out  1  all four lane FIFOs empty.
REQ-018 dispatcher_busy  out  1  CTA scan in progress.
REQ-019 dispatcher_done  out  1  CTA fully scanned and drained.

Function
REQ-020 States: IDLE, SCAN, DRAIN; fetch_done in IDLE latches unrolling_factor, input_register_bitmap, active_mask, cta_size, clears scan pointer (11 bits), clears done, enters SCAN; fetch_done outside IDLE ignored.
REQ-021 dispatcher_busy SHALL be 1 in SCAN and DRAIN (first 1 cycle after fetch_done sampled); 0 in IDLE.
REQ-022 Scoreboard: pending[r][tid] for 32 GPRs + 2 predicates; wb_valid sets (ld_dest_reg[7]=1) or clears (=0) pending[reg][t] for every t set in wb_tid_bitmap; constant registers never tracked or blocking.
REQ-023 Thread t is blocked iff any pending[r][t] is set for a GPR/predicate r selected in the latched bitmap; scoreboard updates take effect the cycle after wb_valid.
REQ-024 SCAN each cycle examines window TIDs ptr..ptr+N-1 (N = lane count); TID ptr+i targets lane i; inactive TIDs skipped.
REQ-025 Window advances (ptr += N) only if no active TID in it is blocked and every target lane FIFO has space; pushes all its active TIDs in that same cycle; otherwise whole window stalls (in-order).
REQ-026 When ptr reaches cta thread count, go to DRAIN; DRAIN -> IDLE when all FIFOs empty, asserting dispatcher_done (held until next fetch_done).
REQ-027 Lane FIFO: pop when dispatch_fifo_pop[i] and non-empty; pop on empty ignored; simultaneous push/pop when full not required (full blocks push).
REQ-028 dispatch_tid_i is don't-care while dispatch_valid_i is 0; outputs derive combinationally from FIFO state.
REQ-029 Each active TID below cta thread count SHALL be dispatched exactly once per CTA.

Reset
REQ-030 Reset clears FIFOs, scoreboard, pointer, latched config; state IDLE; all dispatch_valid, busy, done = 0; dispatch_fifo_empty = 1; reset mid-CTA aborts it.

Structure
REQ-031 Shared package holds lane count, cta_size/unrolling_factor encodings, register-class bit ranges, state enum.
REQ-032 One sub-module: dispatch_lane_fifo (10-bit, FIFO_DEPTH) instantiated four times.

Verification
REQ-033 After reset -> busy=0, done=0, dispatch_fifo_empty=1.
REQ-034 mask[3:0]=1, bitmap=1, cta 256, 4-way -> TIDs 0,1,2,3 on lanes 0-3, total 4, done=1.
REQ-035 mask[15:0]=1 with 1-, 2-, 4-way -> 16 TIDs each, lane use limited to 1/2/4 lanes.
REQ-036 set pending GPR0 for TIDs 0-3, bitmap=7, mask[7:0] -> nothing until wb clears GPR0 for 0x0F, then all 8 dispatched.
REQ-037 bitmap with constants [35:32] only, pending set on GPR0 -> all 4 threads dispatch (constants never block).
REQ-038 Hold pops 0 with 16 threads, 1-way -> scan stalls at FIFO full, resumes on pop, no TID lost or duplicated.
